// File: rtl/hcsr04_distance_meter.sv
// HC-SR04 ultrasonic ranger: periodic trigger, echo pulse width to centimetres, timeout flag.
// Optional 4-sample moving average of the distance when HCSR04_AVG4_EN is defined.
module hcsr04_distance_meter #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TRIG_US     = 10,
  parameter int PERIOD_MS   = 60,
  parameter int TIMEOUT_US  = 25_000,
  parameter int MAX_DIST_CM = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       echo,
  output logic       trig,
  output logic [9:0] distance,
  output logic       dist_valid,
  output logic       timeout_err,
  output logic       busy
);

  localparam int DIV       = CLK_FREQ_HZ / 1_000_000;
  localparam int DIV_W     = $clog2(DIV);
  localparam int PERIOD_US = PERIOD_MS * 1000;
  localparam int PER_W     = $clog2(PERIOD_US + 1);
  localparam int US_MAX    = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int US_W      = $clog2(US_MAX + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t           state, state_next;
  logic             echo_meta, echo_s, echo_prev;
  logic             echo_rise, echo_fall;
  logic [DIV_W-1:0] div_cnt;
  logic             us_tick;
  logic [US_W-1:0]  us_cnt;
  logic [PER_W-1:0] period_cnt;
  logic [5:0]       us_sub;
  logic [9:0]       cm_cnt;
  logic [9:0]       distance_next;
  logic             trig_entry;
  logic             meas_done;
  logic             timeout_hit;

  assign echo_rise  = echo_s & ~echo_prev;
  assign echo_fall  = ~echo_s & echo_prev;
  assign us_tick    = (div_cnt == DIV_W'(DIV - 1));
  assign trig_entry = (state_next == TRIG) && (state != TRIG);
  assign trig       = (state == TRIG);
  assign busy       = (state != IDLE);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next  = state;
    meas_done   = 1'b0;
    timeout_hit = 1'b0;
    if (state != IDLE && !enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      if (enable && !echo_s) state_next = TRIG;
        TRIG:      if (us_tick && us_cnt == US_W'(TRIG_US - 1)) state_next = WAIT_RISE;
        WAIT_RISE: begin
          if (echo_rise) begin
            state_next = MEASURE;
          end else if (us_tick && us_cnt == US_W'(TIMEOUT_US - 1)) begin
            timeout_hit = 1'b1;
            state_next  = HOLDOFF;
          end
        end
        MEASURE: begin
          // A fall on the threshold cycle wins: echo_s is already low, so no timeout tick counts.
          if (echo_fall) begin
            meas_done  = 1'b1;
            state_next = HOLDOFF;
          end else if (echo_s && us_tick && us_cnt == US_W'(TIMEOUT_US - 1)) begin
            timeout_hit = 1'b1;
            state_next  = HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (period_cnt == PER_W'(PERIOD_US) ||
              (us_tick && period_cnt == PER_W'(PERIOD_US - 1)))
            state_next = TRIG;
        end
        default:   state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      echo_meta  <= 1'b0;
      echo_s     <= 1'b0;
      echo_prev  <= 1'b0;
      div_cnt    <= '0;
      period_cnt <= '0;
    end else begin
      state     <= state_next;
      echo_meta <= echo;
      echo_s    <= echo_meta;
      echo_prev <= echo_s;
      if (trig_entry || us_tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;
      if (trig_entry)
        period_cnt <= '0;
      else if (us_tick && period_cnt != PER_W'(PERIOD_US))
        period_cnt <= period_cnt + 1'b1;
    end
  end

  // The tick on the echo-rise cycle already belongs to the echo, so it seeds the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      us_cnt <= '0;
      us_sub <= '0;
      cm_cnt <= '0;
    end else begin
      if (state_next != state)
        us_cnt <= (state_next == MEASURE && us_tick) ? US_W'(1) : '0;
      else if (us_tick && (state == TRIG || state == WAIT_RISE || (state == MEASURE && echo_s)))
        us_cnt <= us_cnt + 1'b1;

      if (state_next == MEASURE && state != MEASURE) begin
        us_sub <= 6'(us_tick);
        cm_cnt <= '0;
      end else if (state == MEASURE && us_tick && echo_s) begin
        if (us_sub == 6'd57) begin
          us_sub <= '0;
          if (cm_cnt != 10'(MAX_DIST_CM)) cm_cnt <= cm_cnt + 1'b1;
        end else begin
          us_sub <= us_sub + 1'b1;
        end
      end
    end
  end

`ifdef HCSR04_AVG4_EN
  logic [9:0]  hist [3];
  logic        hist_full;
  logic [11:0] avg_sum;

  always_comb begin
    avg_sum = hist_full ? 12'(cm_cnt) + 12'(hist[0]) + 12'(hist[1]) + 12'(hist[2])
                        : {cm_cnt, 2'b00};
    distance_next = 10'(avg_sum >> 2);
  end

  // NOTE: the history array needs no reset; hist_full marks it empty and the first sample fills it.
  always_ff @(posedge clk) begin
    if (meas_done) begin
      hist[0] <= cm_cnt;
      hist[1] <= hist_full ? hist[0] : cm_cnt;
      hist[2] <= hist_full ? hist[1] : cm_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          hist_full <= 1'b0;
    else if (meas_done) hist_full <= 1'b1;
  end
`else
  assign distance_next = cm_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      distance    <= '0;
      dist_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dist_valid <= meas_done;
      if (meas_done) begin
        distance    <= distance_next;
        timeout_err <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hcsr04_distance_meter.sv
// Self-checking bench for hcsr04_distance_meter with a scaled clock (2 clk per microsecond).
// Expected distances come from floor(us/58) with saturation, plus a 4-deep average when HCSR04_AVG4_EN is set.
module tb_hcsr04_distance_meter;

  localparam int CLK_FREQ_HZ = 2_000_000;
  localparam int DIV         = CLK_FREQ_HZ / 1_000_000;
  localparam int TRIG_US     = 10;
  localparam int PERIOD_MS   = 2;
  localparam int TIMEOUT_US  = 800;
  localparam int MAX_DIST_CM = 10;

  logic       clk = 1'b0;
  logic       reset, enable, echo;
  logic       trig, dist_valid, timeout_err, busy;
  logic [9:0] distance;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int dv_count = 0;
  int exp_distance = 0;
  int hist_q[$];

  hcsr04_distance_meter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .TRIG_US(TRIG_US), .PERIOD_MS(PERIOD_MS),
    .TIMEOUT_US(TIMEOUT_US), .MAX_DIST_CM(MAX_DIST_CM)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .distance(distance), .dist_valid(dist_valid), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (dist_valid === 1'b1) dv_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (trig !== lvl && n < budget) begin
      step();
      n++;
    end
    check(tag, trig, lvl);
  endtask

  // Reference: floor of echo microseconds over 58, clipped, then optionally averaged over the last four.
  function automatic int model_valid(input int us);
    int cm = us / 58;
    int sum = 0;
    if (cm > MAX_DIST_CM) cm = MAX_DIST_CM;
`ifdef HCSR04_AVG4_EN
    if (hist_q.size() == 0) repeat (4) hist_q.push_back(cm);
    else begin
      hist_q.push_back(cm);
      void'(hist_q.pop_front());
    end
    foreach (hist_q[i]) sum += hist_q[i];
    return sum / 4;
`else
    sum = cm;
    return sum;
`endif
  endfunction

  // Waits for the next trigger, answers with an echo of 'us' microseconds and checks the outcome.
  task automatic measure(input int us, input string tag);
    int dv0;
    bit timed_out;
    wait_trig(1'b1, 5000, {tag, "_trig_rise"});
    wait_trig(1'b0, 100, {tag, "_trig_fall"});
    step(10);
    dv0 = dv_count;
    echo = 1'b1;
    step(us * DIV);
    echo = 1'b0;
    step(20);
    timed_out = (us >= TIMEOUT_US);
    if (!timed_out) exp_distance = model_valid(us);
    check({tag, "_dv_pulses"}, dv_count - dv0, timed_out ? 0 : 1);
    check({tag, "_distance"}, distance, exp_distance);
    check({tag, "_timeout"}, timeout_err, timed_out);
  endtask

  initial begin
    int t_rise, t_fall, n_high, t_next, dv0, n_stale;
    reset = 1'b1; enable = 1'b0; echo = 1'b0;
    step(3);
    check("rst_trig", trig, 0);
    check("rst_distance", distance, 0);
    check("rst_dist_valid", dist_valid, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step(2);

    // Trigger width, echo-rise timeout and trigger period.
    enable = 1'b1;
    wait_trig(1'b1, 10, "first_trig_rise");
    t_rise = cyc;
    check("trig_busy", busy, 1);
    n_high = 0;
    while (trig === 1'b1 && n_high < 100) begin
      n_high++;
      step();
    end
    t_fall = cyc;
    check("trig_width_clk", n_high, TRIG_US * DIV);
    while (timeout_err !== 1'b1 && cyc - t_fall < 3000) step();
    check("wait_rise_timeout", timeout_err, 1);
    check("wait_rise_timeout_clk", cyc - t_fall, TIMEOUT_US * DIV);
    check("holdoff_busy", busy, 1);
    wait_trig(1'b1, 5000, "second_trig_rise");
    t_next = cyc;
    check("trig_period_clk", t_next - t_rise, PERIOD_MS * 1000 * DIV);

    // Directed ranges, then randomized echo widths.
    measure(580, "range_580us");
    measure(57, "range_57us");
    measure(58, "range_58us");
    measure(750, "saturate_750us");
    measure(850, "echo_too_long");
    for (int i = 0; i < 4; i++) measure($urandom_range(1, 640), "random_echo");
    measure(300, "range_300us");

    // Abort in MEASURE: idle on the next cycle, nothing published.
    wait_trig(1'b1, 5000, "abort_trig_rise");
    wait_trig(1'b0, 100, "abort_trig_fall");
    step(10);
    dv0 = dv_count;
    echo = 1'b1;
    step(40);
    enable = 1'b0;
    step();
    check("abort_busy", busy, 0);
    check("abort_trig", trig, 0);
    echo = 1'b0;
    step(20);
    check("abort_no_dv", dv_count - dv0, 0);
    check("abort_distance", distance, exp_distance);
    check("abort_timeout", timeout_err, 0);

    // Stale echo while idle blocks the trigger until it drops.
    echo = 1'b1;
    step(5);
    enable = 1'b1;
    n_stale = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (trig === 1'b1) n_stale++;
    end
    check("stale_no_trig", n_stale, 0);
    check("stale_idle", busy, 0);
    echo = 1'b0;
    wait_trig(1'b1, 10, "stale_released_trig");

    // Synchronous reset during TRIG.
    reset = 1'b1;
    step();
    check("midrst_trig", trig, 0);
    check("midrst_busy", busy, 0);
    check("midrst_distance", distance, 0);
    check("midrst_timeout", timeout_err, 0);
    check("midrst_dist_valid", dist_valid, 0);
    reset = 1'b0;
    enable = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
